// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the memory stage (master) and the data memory responder (slave).
interface data_memory_responder_if;
  logic [63:0] addr;
  logic [63:0] val_write;
  logic        wrEn;
  logic        reEn;
  logic        busy;
  logic        mem_ready;
  logic [63:0] val_read;
  logic        dmem_error;

  modport master (
    output addr, val_write, wrEn, reEn,
    input  busy, mem_ready, val_read, dmem_error
  );

  modport slave (
    input  addr, val_write, wrEn, reEn,
    output busy, mem_ready, val_read, dmem_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// Byte-addressed little-endian data memory servicing one 64-bit read or write at a time,
// completing a fixed number of cycles after the request is accepted.
module data_memory_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]    state;
  logic [3:0]    count;
  logic          busyR;
  logic          readyR;
  logic          errR;
  logic [63:0]   valReadR;

  logic [AW-1:0] reqAddr_p0;
  logic [63:0]   reqData_p0;
  logic          reqWrite_p0;
  logic          reqErr_p0;

  logic [7:0]    mem [MEM_BYTES];

  logic          accept;
  logic          finish;
  logic [AW-1:0] byteIdx [8];
  logic [63:0]   rdWord;

  // The range test runs on the full 64-bit address so huge addresses cannot wrap into range.
  function automatic logic badRequest(input logic [63:0] a, input logic wr, input logic re);
    return (wr & re) | (a > 64'(MEM_BYTES - 8));
  endfunction

  always_comb begin
    accept = (state == IDLE) && (bus.wrEn || bus.reEn);
    finish = (state == WAIT) && (count == 4'd0);
  end

  always_comb begin
    rdWord = '0;
    for (int i = 0; i < 8; i++) begin
      byteIdx[i] = reqAddr_p0 + AW'(i);
      rdWord[8*i +: 8] = mem[byteIdx[i]];
    end
  end

  // Stage p0: capture the request at accept; inputs are ignored until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      reqAddr_p0  <= bus.addr[AW-1:0];
      reqData_p0  <= bus.val_write;
      reqWrite_p0 <= bus.wrEn;
      reqErr_p0   <= badRequest(bus.addr, bus.wrEn, bus.reEn);
    end
  end

  // Completion edge: commit the write, or register the read, then hold DONE for one cycle.
  always_ff @(posedge clk) begin
    if (!reset && finish && reqWrite_p0 && !reqErr_p0) begin
      for (int i = 0; i < 8; i++) begin
        mem[byteIdx[i]] <= reqData_p0[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      busyR    <= 1'b0;
      readyR   <= 1'b0;
      errR     <= 1'b0;
      valReadR <= 64'd0;
    end else begin
      readyR <= 1'b0;
      errR   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= WAIT;
            count <= CNT_INIT;
            busyR <= 1'b1;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state  <= DONE;
            busyR  <= 1'b0;
            readyR <= 1'b1;
            errR   <= reqErr_p0;
            if (!reqErr_p0 && !reqWrite_p0) begin
              valReadR <= rdWord;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busyR;
  assign bus.mem_ready  = readyR;
  assign bus.dmem_error = errR;
  assign bus.val_read   = valReadR;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a byte-array model predicts every completion.
module tb_data_memory_responder;

  localparam int MEM_BYTES = 1024;
  localparam int LATENCY   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  data_memory_responder_if bus ();

  data_memory_responder #(
    .MEM_BYTES (MEM_BYTES),
    .LATENCY   (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        err;
    logic [63:0] val;
  } exp_t;

  exp_t        sbQ [$];
  exp_t        mon;
  logic [7:0]  mdl [MEM_BYTES];
  logic [63:0] lastRead;
  int          testsRun = 0;
  int          testsFailed = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mdlWord(input logic [63:0] a);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mdl[int'(a[15:0]) + i];
    return w;
  endfunction

  task automatic expectReq(input logic wr, input logic re, input logic [63:0] a, input logic [63:0] d);
    logic err;
    err = (wr & re) | (a > 64'(MEM_BYTES - 8));
    if (!err && wr) begin
      for (int i = 0; i < 8; i++) mdl[int'(a[15:0]) + i] = d[8*i +: 8];
    end else if (!err && re) begin
      lastRead = mdlWord(a);
    end
    sbQ.push_back('{err, lastRead});
  endtask

  task automatic doReq(input logic wr, input logic re, input logic [63:0] a, input logic [63:0] d);
    int cycles;
    @(negedge clk);
    bus.wrEn = wr;
    bus.reEn = re;
    bus.addr = a;
    bus.val_write = d;
    expectReq(wr, re, a, d);
    @(negedge clk);
    bus.wrEn = 1'b0;
    bus.reEn = 1'b0;
    bus.addr = {$urandom, $urandom};
    bus.val_write = {$urandom, $urandom};
    checkVal("busy_inflight", bus.busy, 1);
    cycles = 0;
    while (bus.mem_ready !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkVal("latency", cycles, LATENCY);
    checkVal("busy_at_done", bus.busy, 0);
    if (bus.mem_ready !== 1'b1) sbQ.delete();
    @(negedge clk);
    checkVal("ready_one_cycle", bus.mem_ready, 0);
  endtask

  always @(negedge clk) begin
    if (bus.mem_ready === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkVal("unexpected_ready", 1, 0);
      end else begin
        mon = sbQ.pop_front();
        checkVal("dmem_error", bus.dmem_error, mon.err);
        checkVal("val_read", bus.val_read, mon.val);
      end
    end else if (bus.dmem_error === 1'b1) begin
      checkVal("error_without_ready", bus.dmem_error, 0);
    end
  end

  initial begin
    int pulses;
    int busyCycles;
    int lastPulse;
    int cyc;
    for (int i = 0; i < MEM_BYTES; i++) mdl[i] = 8'h00;
    lastRead = '0;
    bus.addr = '0;
    bus.val_write = '0;
    bus.wrEn = 1'b0;
    bus.reEn = 1'b0;

    repeat (3) @(negedge clk);
    checkVal("rst_busy", bus.busy, 0);
    checkVal("rst_ready", bus.mem_ready, 0);
    checkVal("rst_val_read", bus.val_read, 0);
    checkVal("rst_error", bus.dmem_error, 0);
    reset = 1'b0;

    // Aligned write/read, then an unaligned read that pulls in the neighbouring word.
    doReq(1, 0, 64'h18, 64'hA5B6_C7D8_E9F0_1122);
    doReq(1, 0, 64'h10, 64'h0123_4567_89AB_CDEF);
    doReq(0, 1, 64'h10, 64'h0);
    doReq(0, 1, 64'h11, 64'h0);

    // Upper boundary and out-of-range addresses.
    doReq(1, 0, 64'd1016, 64'h1122_3344_5566_7788);
    doReq(0, 1, 64'd1016, 64'h0);
    doReq(0, 1, 64'd1017, 64'h0);
    doReq(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    doReq(1, 0, 64'd1017, 64'hDEAD_BEEF_DEAD_BEEF);
    doReq(0, 1, 64'd1016, 64'h0);

    // Conflicting request must not write; unaligned write overlays part of the word.
    doReq(1, 0, 64'h20, 64'hCAFE_F00D_1234_5678);
    doReq(1, 1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF);
    doReq(0, 1, 64'h20, 64'h0);
    doReq(1, 0, 64'h23, 64'h9988_7766_5544_3322);
    doReq(0, 1, 64'h20, 64'h0);

    // Reset one cycle after a write is accepted discards it.
    doReq(1, 0, 64'h30, 64'h1111_2222_3333_4444);
    @(negedge clk);
    bus.wrEn = 1'b1;
    bus.addr = 64'h30;
    bus.val_write = 64'hDEAD;
    @(negedge clk);
    bus.wrEn = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lastRead = '0;
    checkVal("midrst_busy", bus.busy, 0);
    checkVal("midrst_val_read", bus.val_read, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkVal("midrst_no_ready", bus.mem_ready, 0);
    end
    doReq(0, 1, 64'h30, 64'h0);

    // Continuous read requests; junk driven while busy must be ignored.
    @(negedge clk);
    bus.addr = 64'h10;
    bus.wrEn = 1'b0;
    bus.reEn = 1'b1;
    for (int k = 0; k < 4; k++) expectReq(0, 1, 64'h10, 64'h0);
    pulses = 0;
    busyCycles = 0;
    lastPulse = 0;
    cyc = 0;
    while (pulses < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1) busyCycles++;
      if (bus.mem_ready === 1'b1) begin
        if (pulses > 0) checkVal("ready_period", cyc - lastPulse, 4);
        lastPulse = cyc;
        pulses++;
      end
      if (pulses == 4) begin
        bus.reEn = 1'b0;
        bus.wrEn = 1'b0;
      end else if (bus.busy === 1'b1) begin
        bus.wrEn = 1'b1;
        bus.addr = 64'h20;
        bus.val_write = {$urandom, $urandom};
      end else begin
        bus.wrEn = 1'b0;
        bus.addr = 64'h10;
      end
    end
    bus.reEn = 1'b0;
    bus.wrEn = 1'b0;
    checkVal("stream_pulses", pulses, 4);
    checkVal("stream_busy_cycles", busyCycles, 8);

    repeat (6) @(negedge clk);
    checkVal("scoreboard_empty", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
